deserializer_8b: RTL and testbench
==================================

# deserializer_8b

Receive-side counterpart of the 8-bit LVDS serializer. It takes the single-bit serial line, hunts for the raw start-flag frame, and then slices fixed-period 10-bit frames. Data frames are 8b/10b-decoded; flag frames are passed through unencoded. Decoded bytes, flag markers and error pulses go to the link/framing layer.

## Interface
Parameters:
- FRAME_PERIOD, 11: clocks between first bits of consecutive frames (10 bits + 1 idle gap bit); legal range 10..31
- FLAG_BYTE, 8'h7E: raw (unencoded) delimiter byte

Ports:
- clk  in  1  single clock; serial_i is sampled on its rising edge
- reset  in  1  asynchronous, active-high
- serial_i  in  1  serial line, MSB (frame bit 9) first; idles low
- data_o  out  8  decoded byte, or FLAG_BYTE on flag frames; held between strobes
- valid_o  out  1  one-clock strobe: data_o/flag_o/code_err_o are valid
- flag_o  out  1  qualifies valid_o: frame was the raw flag {2'b00, FLAG_BYTE}
- code_err_o  out  1  qualifies valid_o: data frame not a legal 8b/10b code; data_o = 8'h00
- sync_lost_o  out  1  one-clock pulse: lock dropped on an all-zero frame
- locked_o  out  1  level: inside a packet (between start and end flag)

Reset value of every output: 0.

## Operation
- Shift register sr[9:0] <= {sr[8:0], serial_i} every clock in every state.
- FLAG_WORD = {2'b00, FLAG_BYTE} = 10'b00_0111_1110. The framing layer guarantees no data byte encodes to FLAG_WORD. This is a protocol restriction; the block does not check it.
- Frame counter cnt, 5 bits, counts 0..FRAME_PERIOD-1 and wraps.
- State HUNT:
  - Check sr == FLAG_WORD every clock.
  - On a match: emit flag strobe (valid_o=1, flag_o=1, data_o=FLAG_BYTE), set cnt=0, go to LOCKED, set locked_o=1.
- State LOCKED: evaluate sr only when cnt == FRAME_PERIOD-1.
  - sr == FLAG_WORD: emit flag strobe, set locked_o=0, go to HUNT (end of packet).
  - sr == 10'h000: pulse sync_lost_o (no valid_o), set locked_o=0, go to HUNT.
  - Otherwise: decode sr and emit valid_o=1 with flag_o=0.
    - Legal code: data_o = decoded byte, code_err_o=0.
    - Illegal code: data_o=8'h00, code_err_o=1, stay LOCKED.
- Running disparity is not tracked. The transmitter does not maintain it, so only code legality is checked.
- Back-to-back packets: after an end flag, HUNT can re-detect on the very next window that matches.
- Reset asserted mid-frame: all state clears immediately; the partial frame is discarded and state returns to HUNT.

## Timing
- Output latency: strobes assert on the clock edge after sr holds the complete frame. That is 2 rising edges after the frame's last bit is present on serial_i.
- valid_o and sync_lost_o are exactly one clock wide and are never asserted together.
- With no gaps, at most one valid_o per FRAME_PERIOD clocks.
- In LOCKED, the first evaluation happens FRAME_PERIOD clocks after the flag-detect clock. Once locked, serial_i transitions have no effect on alignment.
- data_o and flag_o hold their values until the next valid_o.
- code_err_o is only meaningful when valid_o=1, and it is held at 0 otherwise.

## Structure
- Shared package serdes_pkg, also used by the serializer:
  - FLAG_BYTE default
  - FLAG_WORD
  - IDLE_WORD (10'h000)
  - state enum {HUNT, LOCKED}
- One sub-module: decode. It is the combinational 8b/10b decoder and mirrors the existing encode bit ordering.
  - Ports: datain[9:0], dataout[7:0], code_err.

## Test plan
- Idle, then start flag: serial_i low for 20 clocks, then 0001111110 → one strobe with valid_o=1, flag_o=1, data_o=8'h7E, 2 edges after the last bit; locked_o=1.
- Packet: start flag, then encode(8'hA5), encode(8'h3C), end flag at an 11-clock period → strobes 7E/flag, A5, 3C, 7E/flag, spaced 11 clocks; locked_o falls with the last strobe.
- Corrupt frame: a locked frame of 10'b1111100000 → valid_o=1, code_err_o=1, data_o=8'h00; the next good frame decodes normally.
- Line dies: stop driving after one data frame while locked → sync_lost_o pulse at the next frame boundary, locked_o=0; a following start flag relocks.
- Reset mid-frame: assert reset at bit 5 of a data frame → all outputs 0 immediately; no strobe for that frame; state is HUNT after release.
- Flag lookalike in idle gap: data frames while in HUNT (no preceding flag) → no valid_o until a FLAG_WORD appears.

Source files
------------

// File: rtl/serdes_pkg.sv
// Shared definitions for the 8-bit LVDS serializer/deserializer pair.
package serdes_pkg;

  localparam logic [7:0] FLAG_BYTE_DEFAULT = 8'h7E;
  localparam logic [9:0] FLAG_WORD         = {2'b00, FLAG_BYTE_DEFAULT};
  localparam logic [9:0] IDLE_WORD         = 10'h000;

  typedef enum logic [0:0] {
    HUNT   = 1'b0,
    LOCKED = 1'b1
  } state_e;

endpackage

// File: rtl/deserializer_8b_decode.sv
// Combinational 8b/10b decoder; datain = {a,b,c,d,e,i,f,g,h,j}, a is the first bit on the line.
// Either running-disparity form of each sub-block is accepted.
module deserializer_8b_decode (
  input  logic [9:0] datain,
  output logic [7:0] dataout,
  output logic       code_err
);

  logic [5:0] abcdei;
  logic [3:0] fghj;
  logic [4:0] edcba;
  logic [2:0] hgf;
  logic       ok6;
  logic       ok4;

  assign abcdei = datain[9:4];
  assign fghj   = datain[3:0];

  always_comb begin
    edcba = 5'd0;
    ok6   = 1'b1;
    case (abcdei)
      6'b100111, 6'b011000: edcba = 5'd0;
      6'b011101, 6'b100010: edcba = 5'd1;
      6'b101101, 6'b010010: edcba = 5'd2;
      6'b110001:            edcba = 5'd3;
      6'b110101, 6'b001010: edcba = 5'd4;
      6'b101001:            edcba = 5'd5;
      6'b011001:            edcba = 5'd6;
      6'b111000, 6'b000111: edcba = 5'd7;
      6'b111001, 6'b000110: edcba = 5'd8;
      6'b100101:            edcba = 5'd9;
      6'b010101:            edcba = 5'd10;
      6'b110100:            edcba = 5'd11;
      6'b001101:            edcba = 5'd12;
      6'b101100:            edcba = 5'd13;
      6'b011100:            edcba = 5'd14;
      6'b010111, 6'b101000: edcba = 5'd15;
      6'b011011, 6'b100100: edcba = 5'd16;
      6'b100011:            edcba = 5'd17;
      6'b010011:            edcba = 5'd18;
      6'b110010:            edcba = 5'd19;
      6'b001011:            edcba = 5'd20;
      6'b101010:            edcba = 5'd21;
      6'b011010:            edcba = 5'd22;
      6'b111010, 6'b000101: edcba = 5'd23;
      6'b110011, 6'b001100: edcba = 5'd24;
      6'b100110:            edcba = 5'd25;
      6'b010110:            edcba = 5'd26;
      6'b110110, 6'b001001: edcba = 5'd27;
      6'b001110:            edcba = 5'd28;
      6'b101110, 6'b010001: edcba = 5'd29;
      6'b011110, 6'b100001: edcba = 5'd30;
      6'b101011, 6'b010100: edcba = 5'd31;
      default:              ok6   = 1'b0;
    endcase
  end

  // Both primary (P7) and alternate (A7) forms decode to 7.
  always_comb begin
    hgf = 3'd0;
    ok4 = 1'b1;
    case (fghj)
      4'b1011, 4'b0100:                   hgf = 3'd0;
      4'b1001:                            hgf = 3'd1;
      4'b0101:                            hgf = 3'd2;
      4'b1100, 4'b0011:                   hgf = 3'd3;
      4'b1101, 4'b0010:                   hgf = 3'd4;
      4'b1010:                            hgf = 3'd5;
      4'b0110:                            hgf = 3'd6;
      4'b1110, 4'b0001, 4'b0111, 4'b1000: hgf = 3'd7;
      default:                            ok4 = 1'b0;
    endcase
  end

  always_comb begin
    code_err = ~(ok6 & ok4);
    dataout  = code_err ? 8'h00 : {hgf, edcba};
  end

endmodule

// File: rtl/deserializer_8b.sv
// Serial receiver: hunts for the raw start flag, then slices fixed-period 10-bit frames
// and 8b/10b-decodes data frames until an end flag or an all-zero frame drops lock.
module deserializer_8b
  import serdes_pkg::*;
#(
  parameter int unsigned FRAME_PERIOD = 11,
  parameter logic [7:0]  FLAG_BYTE    = FLAG_BYTE_DEFAULT
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       serial_i,
  output logic [7:0] data_o,
  output logic       valid_o,
  output logic       flag_o,
  output logic       code_err_o,
  output logic       sync_lost_o,
  output logic       locked_o
);

  localparam logic [9:0] FRAME_FLAG = {2'b00, FLAG_BYTE};
  localparam logic [4:0] CNT_LAST   = 5'(FRAME_PERIOD - 1);

  state_e     state_q, state_d;
  logic [9:0] sr_q, sr_d;
  logic [4:0] cnt_q, cnt_d;
  logic [7:0] data_q, data_d;
  logic       valid_q, valid_d;
  logic       flag_q, flag_d;
  logic       err_q, err_d;
  logic       lost_q, lost_d;
  logic       locked_q, locked_d;

  logic [7:0] dec_data;
  logic       dec_err;

  deserializer_8b_decode u_decode (
    .datain   (sr_q),
    .dataout  (dec_data),
    .code_err (dec_err)
  );

  always_comb begin
    sr_d     = {sr_q[8:0], serial_i};
    cnt_d    = (cnt_q == CNT_LAST) ? 5'd0 : cnt_q + 5'd1;
    state_d  = state_q;
    data_d   = data_q;
    flag_d   = flag_q;
    locked_d = locked_q;
    valid_d  = 1'b0;
    err_d    = 1'b0;
    lost_d   = 1'b0;

    unique case (state_q)
      HUNT: begin
        // Sliding-window search; the frame counter is phased to the detect clock.
        if (sr_q == FRAME_FLAG) begin
          valid_d  = 1'b1;
          flag_d   = 1'b1;
          data_d   = FLAG_BYTE;
          cnt_d    = 5'd0;
          locked_d = 1'b1;
          state_d  = LOCKED;
        end
      end
      LOCKED: begin
        if (cnt_q == CNT_LAST) begin
          if (sr_q == FRAME_FLAG) begin
            valid_d  = 1'b1;
            flag_d   = 1'b1;
            data_d   = FLAG_BYTE;
            locked_d = 1'b0;
            state_d  = HUNT;
          end else if (sr_q == IDLE_WORD) begin
            lost_d   = 1'b1;
            locked_d = 1'b0;
            state_d  = HUNT;
          end else begin
            valid_d = 1'b1;
            flag_d  = 1'b0;
            err_d   = dec_err;
            data_d  = dec_data;
          end
        end
      end
      default: state_d = HUNT;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= HUNT;
      sr_q     <= 10'h000;
      cnt_q    <= 5'd0;
      data_q   <= 8'h00;
      valid_q  <= 1'b0;
      flag_q   <= 1'b0;
      err_q    <= 1'b0;
      lost_q   <= 1'b0;
      locked_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      sr_q     <= sr_d;
      cnt_q    <= cnt_d;
      data_q   <= data_d;
      valid_q  <= valid_d;
      flag_q   <= flag_d;
      err_q    <= err_d;
      lost_q   <= lost_d;
      locked_q <= locked_d;
    end
  end

  assign data_o      = data_q;
  assign valid_o     = valid_q;
  assign flag_o      = flag_q;
  assign code_err_o  = err_q;
  assign sync_lost_o = lost_q;
  assign locked_o    = locked_q;

endmodule

// File: tb/tb_deserializer_8b.sv
// Bench for deserializer_8b: bit streams built from an 8b/10b encoding table, expected outputs
// derived by scanning the stream for flags and frame boundaries.
module tb_deserializer_8b;

  localparam int unsigned P  = 11;
  localparam logic [9:0]  FW = 10'b00_0111_1110;

  localparam logic [5:0] ENC6N [32] = '{
    6'b100111, 6'b011101, 6'b101101, 6'b110001, 6'b110101, 6'b101001, 6'b011001, 6'b111000,
    6'b111001, 6'b100101, 6'b010101, 6'b110100, 6'b001101, 6'b101100, 6'b011100, 6'b010111,
    6'b011011, 6'b100011, 6'b010011, 6'b110010, 6'b001011, 6'b101010, 6'b011010, 6'b111010,
    6'b110011, 6'b100110, 6'b010110, 6'b110110, 6'b001110, 6'b101110, 6'b011110, 6'b101011};
  localparam logic [5:0] ENC6P [32] = '{
    6'b011000, 6'b100010, 6'b010010, 6'b110001, 6'b001010, 6'b101001, 6'b011001, 6'b000111,
    6'b000110, 6'b100101, 6'b010101, 6'b110100, 6'b001101, 6'b101100, 6'b011100, 6'b101000,
    6'b100100, 6'b100011, 6'b010011, 6'b110010, 6'b001011, 6'b101010, 6'b011010, 6'b000101,
    6'b001100, 6'b100110, 6'b010110, 6'b001001, 6'b001110, 6'b010001, 6'b100001, 6'b010100};
  localparam logic [3:0] ENC4N [8] = '{4'b1011, 4'b1001, 4'b0101, 4'b1100,
                                       4'b1101, 4'b1010, 4'b0110, 4'b1110};
  localparam logic [3:0] ENC4P [8] = '{4'b0100, 4'b1001, 4'b0101, 4'b0011,
                                       4'b0010, 4'b1010, 4'b0110, 4'b0001};

  logic       clk = 1'b0;
  logic       reset;
  logic       serial_i;
  logic [7:0] data_o;
  logic       valid_o, flag_o, code_err_o, sync_lost_o, locked_o;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  bit          stim[$];
  logic [12:0] exp_vec[$];
  logic [9:0]  exp_ev[$];
  logic [9:0]  ev_obs[$];
  int          lost_obs;
  bit          mon_en = 1'b0;

  always #5 clk = ~clk;

  deserializer_8b #(
    .FRAME_PERIOD (P),
    .FLAG_BYTE    (8'h7E)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .serial_i    (serial_i),
    .data_o      (data_o),
    .valid_o     (valid_o),
    .flag_o      (flag_o),
    .code_err_o  (code_err_o),
    .sync_lost_o (sync_lost_o),
    .locked_o    (locked_o)
  );

  always @(negedge clk) begin
    if (mon_en) begin
      if (valid_o) ev_obs.push_back({flag_o, code_err_o, data_o});
      if (sync_lost_o) lost_obs++;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [12:0] obs();
    return {valid_o, flag_o, code_err_o, sync_lost_o, locked_o, data_o};
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    assert (got === want) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, want);
    end
  endtask

  // s6/s4 select the disparity variant; s4 = 2/3 selects the A7 form when HGF = 7.
  function automatic logic [9:0] enc(input logic [7:0] b, input int s6, input int s4);
    logic [5:0] six;
    logic [3:0] four;
    six = (s6 != 0) ? ENC6P[b[4:0]] : ENC6N[b[4:0]];
    if (b[7:5] == 3'd7 && s4 >= 2) four = (s4 == 2) ? 4'b0111 : 4'b1000;
    else four = (s4 % 2 != 0) ? ENC4P[b[7:5]] : ENC4N[b[7:5]];
    return {six, four};
  endfunction

  function automatic logic [9:0] enc_rand(input logic [7:0] b);
    logic [9:0] w;
    do w = enc(b, int'($urandom_range(1, 0)), int'($urandom_range(3, 0)));
    while (w == FW);
    return w;
  endfunction

  // Reference decode: search every byte and encoding variant for the word.
  function automatic logic [8:0] mdec(input logic [9:0] w);
    for (int v = 0; v < 256; v++)
      for (int s6 = 0; s6 < 2; s6++)
        for (int s4 = 0; s4 < 4; s4++)
          if (enc(8'(v), s6, s4) == w) return {1'b1, 8'(v)};
    return 9'h000;
  endfunction

  task automatic push_word(input logic [9:0] w);
    for (int i = 9; i >= 0; i--) stim.push_back(w[i]);
    stim.push_back(1'b0);
  endtask

  task automatic push_zeros(input int n);
    repeat (n) stim.push_back(1'b0);
  endtask

  // Expected outputs after each edge k; decisions on window(k) show up after edge k+1.
  task automatic build_model();
    bit         locked = 1'b0;
    int         next_eval = 0;
    logic [7:0] d = 8'h00;
    bit         f = 1'b0;
    bit         v, e, l;
    logic [9:0] win;
    logic [8:0] dec;
    exp_vec.delete();
    exp_ev.delete();
    exp_vec.push_back(13'h0);
    for (int k = 0; k < stim.size() - 1; k++) begin
      win = 10'h0;
      for (int i = k - 9; i <= k; i++) win = {win[8:0], (i >= 0) ? stim[i] : 1'b0};
      v = 1'b0; e = 1'b0; l = 1'b0;
      if (!locked) begin
        if (win == FW) begin
          v = 1'b1; f = 1'b1; d = 8'h7E; locked = 1'b1; next_eval = k + int'(P);
        end
      end else if (k == next_eval) begin
        next_eval = k + int'(P);
        if (win == FW) begin
          v = 1'b1; f = 1'b1; d = 8'h7E; locked = 1'b0;
        end else if (win == 10'h0) begin
          l = 1'b1; locked = 1'b0;
        end else begin
          dec = mdec(win);
          v = 1'b1; f = 1'b0; e = ~dec[8]; d = dec[8] ? dec[7:0] : 8'h00;
        end
      end
      exp_vec.push_back({v, f, e, l, locked, d});
      if (v) exp_ev.push_back({f, e, d});
    end
  endtask

  task automatic do_reset();
    reset    = 1'b1;
    serial_i = 1'b0;
    stim.delete();
    repeat (2) @(negedge clk);
    check("reset_state", 32'(obs()), 32'h0);
    reset = 1'b0;
  endtask

  task automatic run_stream(input string tag);
    build_model();
    ev_obs.delete();
    lost_obs = 0;
    mon_en   = 1'b1;
    for (int k = 0; k < stim.size(); k++) begin
      serial_i = stim[k];
      @(posedge clk);
      @(negedge clk);
      check($sformatf("%s.cyc%0d", tag, k), 32'(obs()), 32'(exp_vec[k]));
    end
    #1 mon_en = 1'b0;
    check({tag, ".n_events"}, 32'(ev_obs.size()), 32'(exp_ev.size()));
    for (int i = 0; i < exp_ev.size() && i < ev_obs.size(); i++)
      check($sformatf("%s.event%0d", tag, i), 32'(ev_obs[i]), 32'(exp_ev[i]));
  endtask

  initial begin
    logic [7:0] r1, r2;
    logic [9:0] w;
    int         nd;

    // Idle then start flag.
    do_reset();
    push_zeros(20);
    push_word(FW);
    push_zeros(7);
    run_stream("idle");
    check("idle.flag_event", 32'(ev_obs[0]), 32'h27E);
    check("idle.locked", 32'(locked_o), 32'h1);

    // Full packet.
    do_reset();
    push_zeros(4);
    push_word(FW);
    push_word(enc_rand(8'hA5));
    push_word(enc_rand(8'h3C));
    push_word(FW);
    push_zeros(4);
    run_stream("packet");
    check("packet.ev0", 32'(ev_obs[0]), 32'h27E);
    check("packet.ev1", 32'(ev_obs[1]), 32'h0A5);
    check("packet.ev2", 32'(ev_obs[2]), 32'h03C);
    check("packet.ev3", 32'(ev_obs[3]), 32'h27E);
    check("packet.unlocked", 32'(locked_o), 32'h0);

    // Corrupt frame, then good frames.
    r1 = 8'($urandom);
    do_reset();
    push_zeros(3);
    push_word(FW);
    push_word(10'b11111_00000);
    push_word(enc_rand(r1));
    push_word(FW);
    push_zeros(3);
    run_stream("corrupt");
    check("corrupt.err_event", 32'(ev_obs[1]), 32'h100);
    check("corrupt.next_good", 32'(ev_obs[2]), {22'h0, 2'b00, r1});

    // Line dies while locked, then relock.
    r1 = 8'($urandom);
    r2 = 8'($urandom);
    do_reset();
    push_zeros(2);
    push_word(FW);
    push_word(enc_rand(r1));
    push_zeros(17);
    push_word(FW);
    push_word(enc_rand(r2));
    push_word(FW);
    push_zeros(3);
    run_stream("linedies");
    check("linedies.lost_pulses", 32'(lost_obs), 32'h1);
    check("linedies.relock_flag", 32'(ev_obs[2]), 32'h27E);
    check("linedies.relock_data", 32'(ev_obs[3]), {22'h0, 2'b00, r2});

    // Reset in the middle of a data frame.
    w = enc_rand(8'($urandom));
    do_reset();
    push_zeros(3);
    push_word(FW);
    for (int i = 9; i >= 5; i--) stim.push_back(w[i]);
    run_stream("rst_a");
    check("rst_a.locked", 32'(locked_o), 32'h1);
    #2 reset = 1'b1;
    #1 check("rst_async_outputs", 32'(obs()), 32'h0);
    @(negedge clk);
    check("rst_held_outputs", 32'(obs()), 32'h0);
    reset = 1'b0;
    stim.delete();
    for (int i = 4; i >= 0; i--) stim.push_back(w[i]);
    stim.push_back(1'b0);
    push_zeros(6);
    push_word(FW);
    push_word(enc_rand(8'($urandom)));
    push_word(FW);
    push_zeros(3);
    run_stream("rst_b");

    // Data frames seen while hunting, then a real packet.
    do_reset();
    push_zeros(2);
    for (int j = 0; j < 4; j++) push_word(enc_rand(8'($urandom)));
    push_zeros(3);
    push_word(FW);
    push_word(enc_rand(8'($urandom)));
    push_word(FW);
    push_zeros(3);
    run_stream("lookalike");

    // Random packets, including back-to-back and illegal codes.
    do_reset();
    for (int p = 0; p < 5; p++) begin
      push_zeros(int'($urandom_range(6, 0)));
      push_word(FW);
      nd = int'($urandom_range(4, 1));
      for (int j = 0; j < nd; j++) begin
        if ($urandom_range(3, 0) == 0) begin
          do w = 10'($urandom);
          while (w == FW || w == 10'h0);
        end else begin
          w = enc_rand(8'($urandom));
        end
        push_word(w);
      end
      push_word(FW);
    end
    push_zeros(4);
    run_stream("random");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
